// File: rtl/icache_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : icache_pkg
//  Description : Shared types and helpers for the direct-mapped instruction
//                cache: FSM state encoding, field-width helpers and
//                address-field extraction functions.
//  Revision    : 1.0 - initial release
// ============================================================================
package icache_pkg;

    localparam int C_ADDR_W = 32;
    localparam int C_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REFILL = 2'd1,
        COMMIT = 2'd2
    } icache_state_t;

    // Field widths derived from the cache geometry.
    function automatic int icache_wb(input int words_per_line);
        return $clog2(words_per_line);
    endfunction

    function automatic int icache_ib(input int lines);
        return $clog2(lines);
    endfunction

    function automatic int icache_tb(input int lines, input int words_per_line);
        return C_ADDR_W - 2 - $clog2(words_per_line) - $clog2(lines);
    endfunction

    function automatic logic [C_ADDR_W-1:0] field_mask(input int width);
        if (width >= C_ADDR_W)
            return '1;
        return (32'd1 << width) - 32'd1;
    endfunction

    // Extraction helpers return a full-width value; callers size-cast the
    // result down to the field width they need.
    function automatic logic [C_ADDR_W-1:0] addr_word(input logic [C_ADDR_W-1:0] a,
                                                     input int wb);
        return (a >> 2) & field_mask(wb);
    endfunction

    function automatic logic [C_ADDR_W-1:0] addr_index(input logic [C_ADDR_W-1:0] a,
                                                      input int wb, input int ib);
        return (a >> (2 + wb)) & field_mask(ib);
    endfunction

    function automatic logic [C_ADDR_W-1:0] addr_tag(input logic [C_ADDR_W-1:0] a,
                                                    input int wb, input int ib);
        return a >> (2 + wb + ib);
    endfunction

endpackage
`default_nettype wire

// File: rtl/icache_data_array.sv
`default_nettype none
// ============================================================================
//  Module      : icache_data_array
//  Description : LINES x WORDS_PER_LINE x 32-bit instruction storage.
//                One synchronous write port, one combinational read port.
//                Contents are not reset.
//  Ports       : clk                       - clock
//                i_we/i_wr_line/i_wr_word  - write enable and location
//                i_wr_data                 - write data
//                i_rd_line/i_rd_word       - read location
//                o_rd_data                 - read data (combinational)
//  Revision    : 1.0 - initial release
// ============================================================================
module icache_data_array
    import icache_pkg::*;
#(
    parameter int LINES          = 16,
    parameter int WORDS_PER_LINE = 4
) (
    input  logic                              clk,
    input  logic                              i_we,
    input  logic [icache_ib(LINES)-1:0]       i_wr_line,
    input  logic [icache_wb(WORDS_PER_LINE)-1:0] i_wr_word,
    input  logic [C_DATA_W-1:0]               i_wr_data,
    input  logic [icache_ib(LINES)-1:0]       i_rd_line,
    input  logic [icache_wb(WORDS_PER_LINE)-1:0] i_rd_word,
    output logic [C_DATA_W-1:0]               o_rd_data
);

    localparam int DEPTH = LINES * WORDS_PER_LINE;

    logic [C_DATA_W-1:0] r_mem [DEPTH];

    // Geometry is power-of-two, so {line, word} is a dense flat address.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[{i_wr_line, i_wr_word}] <= i_wr_data;
        end
    end

    assign o_rd_data = r_mem[{i_rd_line, i_rd_word}];

endmodule
`default_nettype wire

// File: rtl/icache.sv
`default_nettype none
// ============================================================================
//  Module      : icache
//  Description : Direct-mapped read-only instruction cache. Combinational
//                lookup in IDLE; a miss refills the whole line word-serially
//                (word 0 first) over a req/ack handshake, then a COMMIT cycle
//                writes the tag and valid bit. flush invalidates all lines and
//                poisons any in-flight refill.
//  Ports       : clk, rst (sync, active-high)
//                addr       - fetch PC          instr      - word at addr
//                imem_stall - miss/refill busy  flush      - invalidate all
//                mem_req/mem_addr               - refill request and address
//                mem_rdata/mem_ack              - refill data and beat strobe
//  Revision    : 1.0 - initial release
// ============================================================================
module icache
    import icache_pkg::*;
#(
    parameter int LINES          = 16,
    parameter int WORDS_PER_LINE = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr,
    output logic [31:0] instr,
    output logic        imem_stall,
    input  logic        flush,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack
);

    localparam int WB = icache_wb(WORDS_PER_LINE);
    localparam int IB = icache_ib(LINES);
    localparam int TB = icache_tb(LINES, WORDS_PER_LINE);

    localparam logic [WB-1:0] C_LAST_BEAT = WB'(WORDS_PER_LINE - 1);

    // ------------------------------------------------------------------
    // Address split for the current fetch
    // ------------------------------------------------------------------
    logic [WB-1:0] w_word;
    logic [IB-1:0] w_index;
    logic [TB-1:0] w_tag;

    assign w_word  = WB'(addr_word(addr, WB));
    assign w_index = IB'(addr_index(addr, WB, IB));
    assign w_tag   = TB'(addr_tag(addr, WB, IB));

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    icache_state_t r_state;
    icache_state_t w_next;

    logic [LINES-1:0] r_valid;
    logic [TB-1:0]    r_tag_arr [LINES];
    logic [TB-1:0]    r_rtag;
    logic [IB-1:0]    r_rindex;
    logic [WB-1:0]    r_beat;
    logic             r_poison;

    logic             w_hit;
    logic             w_data_we;

    assign w_hit = r_valid[w_index] && (r_tag_arr[w_index] == w_tag);

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state and outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_next     = r_state;
        imem_stall = 1'b1;
        w_data_we  = 1'b0;
        case (r_state)
            IDLE: begin
                imem_stall = ~w_hit;
                if (!flush && !w_hit) begin
                    w_next = REFILL;
                end
            end
            REFILL: begin
                // Gate with rst so a beat landing on the reset edge is dropped.
                w_data_we = mem_ack & ~rst;
                if (mem_ack && (r_beat == C_LAST_BEAT)) begin
                    w_next = COMMIT;
                end
            end
            COMMIT: begin
                w_next = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Control datapath: valid bits, beat counter, memory request
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid  <= '0;
            mem_req  <= 1'b0;
            mem_addr <= '0;
            r_beat   <= '0;
            r_poison <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (flush) begin
                        r_valid <= '0;
                    end else if (!w_hit) begin
                        r_beat   <= '0;
                        mem_req  <= 1'b1;
                        mem_addr <= {w_tag, w_index, {WB{1'b0}}, 2'b00};
                    end
                end
                REFILL: begin
                    // The refill still runs to completion after a flush; only
                    // its final valid-bit update is suppressed.
                    if (flush) begin
                        r_valid  <= '0;
                        r_poison <= 1'b1;
                    end
                    if (mem_ack) begin
                        r_beat   <= r_beat + WB'(1);
                        mem_addr <= mem_addr + 32'd4;
                        if (r_beat == C_LAST_BEAT) begin
                            mem_req <= 1'b0;
                        end
                    end
                end
                COMMIT: begin
                    if (flush) begin
                        r_valid <= '0;
                    end else if (!r_poison) begin
                        r_valid[r_rindex] <= 1'b1;
                    end
                    r_poison <= 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Tag storage and refill target capture (not reset)
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if ((r_state == IDLE) && !flush && !w_hit) begin
            r_rtag   <= w_tag;
            r_rindex <= w_index;
        end
        if (r_state == COMMIT) begin
            r_tag_arr[r_rindex] <= r_rtag;
        end
    end

    // ------------------------------------------------------------------
    // Data storage
    // ------------------------------------------------------------------
    icache_data_array #(
        .LINES          (LINES),
        .WORDS_PER_LINE (WORDS_PER_LINE)
    ) u_data_array (
        .clk       (clk),
        .i_we      (w_data_we),
        .i_wr_line (r_rindex),
        .i_wr_word (r_beat),
        .i_wr_data (mem_rdata),
        .i_rd_line (w_index),
        .i_rd_word (w_word),
        .o_rd_data (instr)
    );

endmodule
`default_nettype wire

// File: tb/tb_icache.sv
`default_nettype none
// ============================================================================
//  Module      : tb_icache
//  Description : Self-checking bench for icache. Stimulus queues expected
//                fetch results and refill addresses; a fetch monitor and a
//                memory responder pop and compare them.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_icache;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] addr = 32'h100;
    logic [31:0] instr;
    logic        imem_stall;
    logic        flush = 1'b0;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [31:0] mem_rdata = '0;
    logic        mem_ack = 1'b0;

    always #5 clk = ~clk;

    icache #(
        .LINES          (16),
        .WORDS_PER_LINE (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .addr       (addr),
        .instr      (instr),
        .imem_stall (imem_stall),
        .flush      (flush),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_rdata  (mem_rdata),
        .mem_ack    (mem_ack)
    );

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [31:0] instr;
        int          stall;
    } exp_t;

    exp_t        mq[$];   // expected fetch results
    logic [31:0] aq[$];   // expected refill addresses, in order
    exp_t        mon_e;
    int          mon_cnt = 0;
    int          gap = 0;
    bit          mem_en = 1'b1;
    bit          force_ack = 1'b0;
    int          wcnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Backing memory image: line 0x100 holds 0xA0..0xA3, everything else
    // returns a marker built from its own address.
    function automatic logic [31:0] mem_val(input logic [31:0] a);
        if (a >= 32'h100 && a < 32'h110)
            return 32'hA0 + ((a - 32'h100) >> 2);
        return {16'hBEEF, a[15:0]};
    endfunction

    task automatic push_line(input logic [31:0] base);
        for (int i = 0; i < 4; i++) aq.push_back(base + 32'(i * 4));
    endtask

    task automatic expect_fetch(input logic [31:0] ei, input int es);
        exp_t e;
        e.instr = ei;
        e.stall = es;
        mq.push_back(e);
    endtask

    task automatic wait_done();
        int n = 0;
        while (mq.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (mq.size() != 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL fetch_timeout: %0d results outstanding, expected 0", mq.size());
            mq.delete();
        end
    endtask

    task automatic fetch(input logic [31:0] a, input logic [31:0] ei, input int es);
        logic [31:0] base;
        @(posedge clk);
        #1;
        addr = a;
        base = a & 32'hFFFF_FFF0;
        if (es > 0) push_line(base);
        expect_fetch(ei, es);
        wait_done();
    endtask

    // Fetch monitor: counts stall cycles while a result is pending and checks
    // instr once the stall drops.
    always @(negedge clk) begin
        if (mq.size() == 0) begin
            mon_cnt = 0;
        end else if (imem_stall) begin
            mon_cnt++;
        end else begin
            mon_e = mq.pop_front();
            chk("instr", instr, mon_e.instr);
            chk("stall_cycles", mon_cnt, mon_e.stall);
            mon_cnt = 0;
        end
    end

    // Memory responder: acks after 'gap' idle cycles, checks each refill
    // address and that it stays put while waiting.
    initial begin
        forever begin
            @(posedge clk);
            #2;
            mem_ack = 1'b0;
            if (force_ack) begin
                mem_ack   = 1'b1;
                mem_rdata = 32'hDEAD_DEAD;
            end else if (mem_req && mem_en && !rst) begin
                if (wcnt == gap) begin
                    wcnt = 0;
                    if (aq.size() == 0) begin
                        n_checks++;
                        n_errors++;
                        $display("FAIL unexpected_req: mem_addr 0x%08h, no refill expected", mem_addr);
                    end else begin
                        chk("mem_addr", mem_addr, aq.pop_front());
                    end
                    mem_rdata = mem_val(mem_addr);
                    mem_ack   = 1'b1;
                end else begin
                    if (aq.size() != 0) chk("mem_addr_hold", mem_addr, aq[0]);
                    wcnt++;
                end
            end else begin
                wcnt = 0;
            end
        end
    end

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_stall", {31'd0, imem_stall}, 32'd1);
        chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);

        // Cold miss on 0x100, then a hit in the same line
        @(posedge clk);
        #1;
        rst = 1'b0;
        push_line(32'h100);
        expect_fetch(32'hA0, 6);
        wait_done();
        fetch(32'h108, 32'hA2, 0);

        // Conflict on index 0
        fetch(32'h200, 32'hBEEF_0200, 6);
        fetch(32'h100, 32'hA0, 6);

        // Slow memory: 3 idle cycles before every ack
        gap = 3;
        fetch(32'h300, 32'hBEEF_0300, 18);
        gap = 0;
        fetch(32'h304, 32'hBEEF_0304, 0);
        fetch(32'h308, 32'hBEEF_0308, 0);
        fetch(32'h30C, 32'hBEEF_030C, 0);

        // Flush in IDLE after a fill of 0x100
        fetch(32'h100, 32'hA0, 6);
        @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        push_line(32'h100);
        expect_fetch(32'hA0, 6);
        wait_done();

        // Flush while beat 2 is outstanding: line stays invalid, refetched
        @(posedge clk);
        #1;
        addr = 32'h200;
        push_line(32'h200);
        push_line(32'h200);
        expect_fetch(32'hBEEF_0200, 12);
        repeat (3) @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        wait_done();

        // Reset during refill, then a stray ack in IDLE
        @(posedge clk);
        #1;
        addr = 32'h100;
        aq.push_back(32'h100);
        aq.push_back(32'h104);
        repeat (3) @(posedge clk);
        #1;
        rst    = 1'b1;
        mem_en = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("rstmid_mem_req", {31'd0, mem_req}, 32'd0);
        chk("rstmid_stall", {31'd0, imem_stall}, 32'd1);
        @(posedge clk);
        #1;
        rst       = 1'b0;
        addr      = 32'h200;
        force_ack = 1'b1;
        @(negedge clk);
        chk("rstmid_no_valid", {31'd0, imem_stall}, 32'd1);
        chk("stray_mem_req", {31'd0, mem_req}, 32'd0);
        @(posedge clk);
        #1;
        force_ack = 1'b0;
        @(negedge clk);
        chk("post_stray_req", {31'd0, mem_req}, 32'd1);
        chk("post_stray_addr", mem_addr, 32'h200);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst    = 1'b0;
        mem_en = 1'b1;
        push_line(32'h200);
        expect_fetch(32'hBEEF_0200, 6);
        wait_done();

        chk("refills_consumed", aq.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
